// File: rtl/seq_pkg.sv
// Shared types and defaults for the program sequencer and its run counter.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        REPORT = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    localparam int SEQ_ADDR_W = 8;
    localparam int SEQ_CYC_W  = 16;

endpackage

// File: rtl/program_sequencer_run_counter.sv
// Run-length counter: cleared on launch, counts RUN cycles, flags the timeout limit.
module run_counter #(
    parameter int          CYC_W   = 16,
    parameter int unsigned TIMEOUT = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CYC_W-1:0] count,
    output logic [CYC_W-1:0] count_inc,
    output logic             hit_limit
);

    // count_inc is the length including the current RUN cycle; it never exceeds
    // TIMEOUT because the sequencer leaves RUN when the limit is reached.
    assign count_inc = count + CYC_W'(1);
    assign hit_limit = (count_inc == CYC_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Boot/run controller: launches each program in START_ADDRS, times it until halt
// or timeout, and reports cycle count and halting PC before the next launch.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int                          NUM_PROGS   = 3,
    parameter int                          ADDR_W      = SEQ_ADDR_W,
    parameter int                          CYC_W       = SEQ_CYC_W,
    parameter int unsigned                 TIMEOUT     = 16'hFFFF,
    parameter logic [NUM_PROGS*ADDR_W-1:0] START_ADDRS = {8'd128, 8'd64, 8'd0},
    localparam int                         IDX_W       = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic              f_clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              halt,
    input  logic [ADDR_W-1:0] pc,
    output logic              start,
    output logic [ADDR_W-1:0] start_addr,
    output logic              busy,
    output logic              done,
    output logic              result_valid,
    output logic [IDX_W-1:0]  prog_idx_o,
    output logic [CYC_W-1:0]  cycles_o,
    output logic [ADDR_W-1:0] halt_pc_o,
    output logic              timeout_o,
    output seq_state_t        state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PROGS - 1);

    seq_state_t       state_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             latch;
    logic             timed_out;
    logic [CYC_W-1:0] count;
    logic [CYC_W-1:0] count_inc;
    logic             hit_limit;

    run_counter #(
        .CYC_W   (CYC_W),
        .TIMEOUT (TIMEOUT)
    ) u_run_counter (
        .clk       (f_clk),
        .rst_n     (rst_n),
        .clear     (state == LAUNCH),
        .enable    (state == RUN),
        .count     (count),
        .count_inc (count_inc),
        .hit_limit (hit_limit)
    );

    always_comb begin
        state_next = state;
        idx_next   = idx;
        latch      = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (go) begin
                    state_next = LAUNCH;
                    idx_next   = '0;
                end
            end
            LAUNCH: state_next = RUN;
            RUN: begin
                // halt takes priority over a simultaneous timeout
                if (halt) begin
                    state_next = REPORT;
                    latch      = 1'b1;
                end else if (hit_limit) begin
                    state_next = REPORT;
                    latch      = 1'b1;
                    timed_out  = 1'b1;
                end
            end
            REPORT: begin
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx + IDX_W'(1);
                    state_next = LAUNCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Every output is a flop loaded from the next-state decode, so none is
    // combinational from an input.
    always_ff @(posedge f_clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            start        <= 1'b0;
            start_addr   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            prog_idx_o   <= '0;
            cycles_o     <= '0;
            halt_pc_o    <= '0;
            timeout_o    <= 1'b0;
        end else begin
            state        <= state_next;
            idx          <= idx_next;
            start        <= (state_next == LAUNCH);
            busy         <= (state_next == LAUNCH) || (state_next == RUN) || (state_next == REPORT);
            done         <= (state_next == DONE);
            result_valid <= (state_next == REPORT);
            if (state_next == LAUNCH) begin
                start_addr <= START_ADDRS[int'(idx_next)*ADDR_W +: ADDR_W];
            end
            if (latch) begin
                prog_idx_o <= idx;
                cycles_o   <= count_inc;
                halt_pc_o  <= timed_out ? '0 : pc;
                timeout_o  <= timed_out;
            end
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench: a three-program instance (TIMEOUT=20) and a single-program
// instance, each driven by a small fetch-unit model.
module tb_program_sequencer;
    import seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    // three-program instance
    logic       go_a, halt_a, halt_en_a, halt_force_a;
    logic [7:0] pc_a;
    logic       start_a, busy_a, done_a, rv_a, to_a;
    logic [7:0] start_addr_a, halt_pc_a;
    logic [1:0] idx_a;
    logic [15:0] cycles_a;
    seq_state_t state_a;

    // single-program instance
    logic       go_b, halt_b;
    logic [7:0] pc_b;
    logic       start_b, busy_b, done_b, rv_b, to_b;
    logic [7:0] start_addr_b, halt_pc_b;
    logic [0:0] idx_b;
    logic [15:0] cycles_b;
    seq_state_t state_b;

    program_sequencer #(
        .NUM_PROGS (3),
        .TIMEOUT   (20)
    ) dut_a (
        .f_clk        (clk),
        .rst_n        (rst_n),
        .go           (go_a),
        .halt         (halt_a),
        .pc           (pc_a),
        .start        (start_a),
        .start_addr   (start_addr_a),
        .busy         (busy_a),
        .done         (done_a),
        .result_valid (rv_a),
        .prog_idx_o   (idx_a),
        .cycles_o     (cycles_a),
        .halt_pc_o    (halt_pc_a),
        .timeout_o    (to_a),
        .state        (state_a)
    );

    program_sequencer #(
        .NUM_PROGS   (1),
        .START_ADDRS (8'd0)
    ) dut_b (
        .f_clk        (clk),
        .rst_n        (rst_n),
        .go           (go_b),
        .halt         (halt_b),
        .pc           (pc_b),
        .start        (start_b),
        .start_addr   (start_addr_b),
        .busy         (busy_b),
        .done         (done_b),
        .result_valid (rv_b),
        .prog_idx_o   (idx_b),
        .cycles_o     (cycles_b),
        .halt_pc_o    (halt_pc_b),
        .timeout_o    (to_b),
        .state        (state_b)
    );

    // fetch-unit models: load on start, otherwise advance one instruction per cycle
    always @(posedge clk) begin
        if (!rst_n) begin
            pc_a <= 8'd0;
            pc_b <= 8'd0;
        end else begin
            pc_a <= start_a ? start_addr_a : pc_a + 8'd1;
            pc_b <= start_b ? start_addr_b : pc_b + 8'd1;
        end
    end

    assign halt_a = halt_force_a | (halt_en_a & (pc_a == 8'h04 || pc_a == 8'h48 || pc_a == 8'h81));
    assign halt_b = (pc_b == 8'h00);

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rv(input int limit, output int steps);
        steps = 0;
        do begin
            cyc();
            steps++;
        end while (rv_a !== 1'b1 && steps < limit);
    endtask

    int steps;
    int seen;

    initial begin
        rst_n = 1'b0; go_a = 1'b0; go_b = 1'b0;
        halt_en_a = 1'b1; halt_force_a = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;

        // idle: ten cycles with go low
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (start_a === 1'b1 || start_b === 1'b1) seen++;
        end
        check("idle_start_never", seen, 0);
        check("idle_state_a", 32'(state_a), 32'(IDLE));
        check("idle_outs_a", {start_a, busy_a, done_a, rv_a, to_a, idx_a, start_addr_a, halt_pc_a, cycles_a},
              32'd0);
        check("idle_outs_b", {start_b, busy_b, done_b, rv_b, to_b, idx_b, start_addr_b, halt_pc_b, cycles_b},
              32'd0);

        // single program halting on its first instruction
        go_b = 1'b1;
        cyc();
        go_b = 1'b0;
        check("b_launch_start", start_b, 1);
        check("b_launch_busy", busy_b, 1);
        cyc();
        check("b_run_start", start_b, 0);
        check("b_run_rv", rv_b, 0);
        cyc();
        check("b_rep_rv", rv_b, 1);
        check("b_rep_cycles", cycles_b, 1);
        check("b_rep_pc", halt_pc_b, 0);
        check("b_rep_to", to_b, 0);
        check("b_rep_idx", idx_b, 0);
        cyc();
        check("b_done", done_b, 1);
        check("b_done_busy", busy_b, 0);
        check("b_done_rv", rv_b, 0);
        check("b_done_start", start_b, 0);

        // three programs halting after 5, 9 and 2 RUN cycles
        go_a = 1'b1;
        cyc();
        go_a = 1'b0;
        check("p0_start", start_a, 1);
        check("p0_addr", start_addr_a, 8'd0);
        wait_rv(30, steps);
        check("p0_latency", steps, 6);
        check("p0_idx", idx_a, 0);
        check("p0_cycles", cycles_a, 5);
        check("p0_pc", halt_pc_a, 8'h04);
        check("p0_to", to_a, 0);
        cyc();
        check("p1_start", start_a, 1);
        check("p1_addr", start_addr_a, 8'd64);
        check("p0_rv_pulse", rv_a, 0);
        check("p0_cycles_hold", cycles_a, 5);
        wait_rv(30, steps);
        check("p1_latency", steps, 10);
        check("p1_idx", idx_a, 1);
        check("p1_cycles", cycles_a, 9);
        check("p1_pc", halt_pc_a, 8'h48);
        cyc();
        check("p2_start", start_a, 1);
        check("p2_addr", start_addr_a, 8'd128);
        wait_rv(30, steps);
        check("p2_latency", steps, 3);
        check("p2_idx", idx_a, 2);
        check("p2_cycles", cycles_a, 2);
        check("p2_pc", halt_pc_a, 8'h81);

        // go in DONE restarts at program 0; program 0 then times out
        cyc();
        check("seq_done", done_a, 1);
        check("seq_done_state", 32'(state_a), 32'(DONE));
        halt_en_a = 1'b0;
        go_a = 1'b1;
        cyc();
        go_a = 1'b0;
        check("restart_done_low", done_a, 0);
        check("restart_start", start_a, 1);
        check("restart_addr", start_addr_a, 8'd0);
        wait_rv(40, steps);
        check("to_latency", steps, 21);
        check("to_cycles", cycles_a, 20);
        check("to_flag", to_a, 1);
        check("to_pc", halt_pc_a, 0);
        check("to_idx", idx_a, 0);
        cyc();
        check("to_advance_start", start_a, 1);
        check("to_advance_addr", start_addr_a, 8'd64);

        // halt on RUN cycle 20 beats the timeout
        repeat (20) cyc();
        halt_force_a = 1'b1;
        cyc();
        halt_force_a = 1'b0;
        check("tie_rv", rv_a, 1);
        check("tie_to", to_a, 0);
        check("tie_cycles", cycles_a, 20);
        check("tie_pc", halt_pc_a, 8'h53);
        check("tie_idx", idx_a, 1);

        // stale halt during LAUNCH and go pulsed during RUN
        cyc();
        check("stale_start", start_a, 1);
        halt_force_a = 1'b1;
        cyc();
        halt_force_a = 1'b0;
        check("stale_run1_rv", rv_a, 0);
        cyc();
        go_a = 1'b1;
        check("stale_run2_rv", rv_a, 0);
        cyc();
        go_a = 1'b0;
        check("stale_run3_rv", rv_a, 0);
        check("stale_run3_start", start_a, 0);
        cyc();
        check("stale_run4_rv", rv_a, 0);
        halt_force_a = 1'b1;
        cyc();
        halt_force_a = 1'b0;
        check("stale_rep_rv", rv_a, 1);
        check("stale_rep_cycles", cycles_a, 4);
        check("stale_rep_pc", halt_pc_a, 8'h83);
        check("stale_rep_idx", idx_a, 2);
        cyc();
        check("ignored_go_done", done_a, 1);
        check("ignored_go_start", start_a, 0);
        cyc();
        check("ignored_go_state", 32'(state_a), 32'(DONE));
        check("ignored_go_start2", start_a, 0);

        // reset in RUN cycle 3
        go_a = 1'b1;
        cyc();
        go_a = 1'b0;
        check("mid_start", start_a, 1);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (rv_a === 1'b1) seen++;
        end
        check("mid_run_state", 32'(state_a), 32'(RUN));
        rst_n = 1'b0;
        cyc();
        if (rv_a === 1'b1) seen++;
        check("mid_no_report", seen, 0);
        check("mid_state", 32'(state_a), 32'(IDLE));
        check("mid_outs_a", {start_a, busy_a, done_a, rv_a, to_a, idx_a, start_addr_a, halt_pc_a, cycles_a},
              32'd0);
        check("mid_outs_b", {start_b, busy_b, done_b, rv_b, to_b, idx_b, start_addr_b, halt_pc_b, cycles_b},
              32'd0);
        rst_n = 1'b1;
        repeat (3) cyc();
        check("post_reset_idle", 32'(state_a), 32'(IDLE));
        check("post_reset_start", start_a, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Upstream boot/run controller for the 8-bit lab processor. It drives the fetch unit's `start`/`start_addr` pair and launches a fixed list of programs back to back. For each program it waits for the decoder's `halt`, measures the run length in clock cycles, and reports the count and halting PC before launching the next entry. It replaces hand-written `start` pulses in test benches and provides a repeatable multi-program run harness.

## Interface
Parameters:
- `NUM_PROGS`, 3: number of programs in the launch list; minimum 1.
- `ADDR_W`, 8: PC/address width; matches the fetch unit.
- `CYC_W`, 16: cycle counter width.
- `TIMEOUT`, 16'hFFFF: RUN-cycle limit before a program is abandoned; must be ≥1 and ≤ 2^CYC_W−1.
- `START_ADDRS`, {8'd128, 8'd64, 8'd0}: packed list of `NUM_PROGS*ADDR_W` bits; program i is at bits [i*ADDR_W +: ADDR_W].

Ports:
- `f_clk` in 1: system clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `go` in 1: request a full sequence; sampled only in IDLE and DONE.
- `halt` in 1: halt flag from the decoder for the current instruction.
- `pc` in ADDR_W: current PC from the fetch unit.
- `start` out 1: to fetch unit; loads `start_addr` into PC.
- `start_addr` out ADDR_W: launch address for the current program.
- `busy` out 1: high in LAUNCH, RUN and REPORT.
- `done` out 1: high in DONE.
- `result_valid` out 1: one-cycle pulse per program.
- `prog_idx_o` out $clog2(NUM_PROGS) (minimum 1): index of the reported program.
- `cycles_o` out CYC_W: reported run length.
- `halt_pc_o` out ADDR_W: PC at which `halt` was seen; 0 on timeout.
- `timeout_o` out 1: reported program hit `TIMEOUT`.

## Operation
- Reset: state=IDLE. All outputs 0 (`start`, `start_addr`, `busy`, `done`, `result_valid`, `prog_idx_o`, `cycles_o`, `halt_pc_o`, `timeout_o`). Internal index and counter are 0. Reset mid-run abandons the sequence with no report.
- States:
  - **IDLE**: waits for `go`; `go`=1 → LAUNCH with index=0.
  - **LAUNCH**: one cycle. `start`=1 and `start_addr`=START_ADDRS[index]. Counter cleared. `halt` is ignored in this state. Always → RUN.
  - **RUN**: `start`=0; `start_addr` holds its value. Each cycle the counter increments by 1, so the first RUN cycle yields a count of 1.
    - `halt`=1 → latch count (including the current cycle), `pc` and timeout=0; go to REPORT.
    - Otherwise, if count == TIMEOUT → latch count=TIMEOUT, halt_pc=0 and timeout=1; go to REPORT.
    - If `halt` and the timeout occur in the same cycle, `halt` wins (timeout=0).
  - **REPORT**: one cycle. `result_valid`=1, and `prog_idx_o`/`cycles_o`/`halt_pc_o`/`timeout_o` present the latched values. These outputs hold after the pulse until the next REPORT.
    - If index == NUM_PROGS−1 → DONE.
    - Otherwise index+1 → LAUNCH.
  - **DONE**: `done`=1. `go`=1 clears `done` and restarts at program 0 (→ LAUNCH); there is no pass through IDLE.
- `go` asserted in LAUNCH, RUN or REPORT is ignored and not queued.
- The counter never wraps; TIMEOUT bounds it.
- The index is a wrap-free compare against NUM_PROGS−1. NUM_PROGS=1 goes straight from REPORT to DONE.

## Timing
- All outputs are registered; none is combinational from inputs.
- Cycle 0: IDLE samples `go`=1. Cycle 1: LAUNCH, `start`=1. The fetch unit loads the PC on the rising edge ending cycle 1. Cycle 2: first RUN cycle, in which `pc`=start_addr and `halt` is valid.
- A halt seen in RUN cycle n (1-based) → REPORT on the next cycle with `cycles_o`=n. The next LAUNCH follows immediately after, so the inter-program gap is 2 cycles (REPORT + LAUNCH).
- A timed-out program reports exactly TIMEOUT+1 cycles after LAUNCH.
- Latency from `go` to the first `result_valid` is n+2 cycles.

## Structure
- Shared package `seq_pkg` holds:
  - `seq_state_t` enum: IDLE, LAUNCH, RUN, REPORT, DONE.
  - Defaults `SEQ_ADDR_W`=8 and `SEQ_CYC_W`=16.
- Sub-module `run_counter`: CYC_W counter with sync clear, enable, and a `hit_limit` compare against TIMEOUT.
- The FSM, index register and result latches stay in the top module.

## Test plan
- Reset and idle: hold `rst_n`=0 for 2 cycles, then keep `go`=0 for 10 cycles → all outputs 0, state IDLE, `start` never asserted.
- Halt on first instruction: model `halt`=1 whenever `pc`==0, with NUM_PROGS=1 and address 0 → `start` high exactly 1 cycle; one `result_valid` with `cycles_o`=1, `halt_pc_o`=0, `timeout_o`=0; `done`=1 on the following cycle.
- Three programs: halt after 5, 9 and 2 RUN cycles at PCs 8'h04, 8'h48 and 8'h81 → three pulses reporting prog_idx 0/1/2, cycles 5/9/2 and matching halt PCs. Each pulse is followed by `start` with `start_addr` 64, 128, then DONE.
- Timeout: TIMEOUT=20, `halt` held 0 → `cycles_o`=20, `timeout_o`=1, `halt_pc_o`=0, and the sequencer advances to the next program. Separately, with `halt`=1 on RUN cycle 20 → `timeout_o`=0, `cycles_o`=20.
- Stale halt and ignored go: `halt`=1 during LAUNCH only, and pulse `go` during RUN → no early report, no restart; counting proceeds normally.
- Reset mid-run plus restart: pull `rst_n` low in RUN cycle 3 → all outputs 0 on the next cycle with no `result_valid`. After the sequence completes, `go` in DONE → `done` drops and LAUNCH of program 0 occurs on the following cycle.
